// File: rtl/timer_irq_sched_if.sv
// timer_irq_sched_if: CPU-side bus of the interrupt scheduler.
// Config writes and the irq/ack handshake; master = CPU, slave = scheduler.
interface timer_irq_sched_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int ID_W = $clog2(NCH);

  logic             cfg_we;
  logic [ID_W-1:0]  cfg_ch;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_reload;
  logic             irq_ack;
  logic             irq;
  logic [ID_W-1:0]  irq_id;

  modport master (
    output cfg_we, cfg_ch, cfg_en, cfg_reload, irq_ack,
    input  irq, irq_id
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_en, cfg_reload, irq_ack,
    output irq, irq_id
  );
endinterface

// File: rtl/timer_irq_sched.sv
// timer_irq_sched: multi-channel periodic interrupt scheduler.
// A prescaler produces a base tick; NCH reloadable down-counters expire on
// those ticks and set sticky pending flags, which are arbitrated onto a single
// irq/irq_id line with an ack handshake and a guaranteed low gap cycle.
// Define TIMER_IRQ_RR_EN for round-robin arbitration; otherwise the
// lowest-index pending channel wins.
module timer_irq_sched #(
  parameter int PRESCALE = 50000,
  parameter int NCH      = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_sched_if.slave bus,
  output logic [NCH-1:0]   overrun,
  output logic             tick
);
  localparam int ID_W = $clog2(NCH);
  localparam int PW   = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt    [NCH];
  logic [CNT_W-1:0] reload [NCH];
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   cfg_hit;
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   ack_clr;
  logic [NCH-1:0]   cand;
  logic             drop;
  logic             ack_ok;
  logic             irq_r;
  logic [ID_W-1:0]  id_r;
  logic [ID_W-1:0]  winner;
  logic             found;
  int unsigned      idx;
`ifdef TIMER_IRQ_RR_EN
  logic [ID_W-1:0]  last_id;
`endif

  // Base tick strobe decoded from the prescaler count.
  always_comb begin
    tick = (presc == PW'(PRESCALE - 1));
  end

  // Prescaler counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // Per-channel config hits, expiries and acknowledge clears.
  always_comb begin
    cfg_hit = '0;
    expire  = '0;
    ack_clr = '0;
    drop    = (state == REQ) && bus.cfg_we && (bus.cfg_ch == id_r);
    ack_ok  = (state == REQ) && irq_r && bus.irq_ack && !drop;
    for (int unsigned i = 0; i < NCH; i++) begin
      cfg_hit[i] = bus.cfg_we && (bus.cfg_ch == ID_W'(i));
      expire[i]  = !cfg_hit[i] && en[i] && tick && (cnt[i] == '0);
      ack_clr[i] = ack_ok && (id_r == ID_W'(i));
    end
    // A channel being rewritten this cycle is not a candidate for a grant.
    cand = pending & ~cfg_hit;
  end

  // Pick the granted channel among the candidates.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
`ifdef TIMER_IRQ_RR_EN
      idx = (32'(last_id) + 1 + k) % NCH;
`else
      idx = k;
`endif
      if (cand[idx] && !found) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Channel counters, enables and sticky pending/overrun flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= '0;
      pending <= '0;
      overrun <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        reload[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          reload[i]  <= bus.cfg_reload;
          cnt[i]     <= bus.cfg_reload;
          en[i]      <= bus.cfg_en;
          pending[i] <= 1'b0;
          overrun[i] <= 1'b0;
        end else begin
          if (en[i] && tick)
            cnt[i] <= (cnt[i] == '0) ? reload[i] : cnt[i] - CNT_W'(1);
          // An ack coinciding with a fresh expiry consumes the old event, so
          // the new one stays pending without being counted as an overrun.
          if (expire[i]) begin
            pending[i] <= 1'b1;
            if (pending[i] && !ack_clr[i]) overrun[i] <= 1'b1;
          end else if (ack_clr[i]) begin
            pending[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Request FSM; irq rises on the cycle after the grant is latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      irq_r   <= 1'b0;
      id_r    <= '0;
`ifdef TIMER_IRQ_RR_EN
      last_id <= ID_W'(NCH - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          irq_r <= 1'b0;
          if (|cand) begin
            id_r    <= winner;
            state   <= REQ;
`ifdef TIMER_IRQ_RR_EN
            last_id <= winner;
`endif
          end
        end
        REQ: begin
          if (drop || ack_ok) begin
            irq_r <= 1'b0;
            state <= GAP;
          end else begin
            irq_r <= 1'b1;
          end
        end
        GAP: begin
          irq_r <= 1'b0;
          state <= IDLE;
        end
        default: begin
          irq_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the bus outputs from the registered request.
  always_comb begin
    bus.irq    = irq_r;
    bus.irq_id = id_r;
  end
endmodule

// File: tb/tb_timer_irq_sched.sv
// tb_timer_irq_sched: randomized bench for timer_irq_sched with a behavioural
// reference model, per-cycle output comparison and directed literal checks.
module tb_timer_irq_sched;
  localparam int PRESCALE = 4;
  localparam int NCH      = 4;
  localparam int CNT_W    = 8;
`ifdef TIMER_IRQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] overrun;
  logic           tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int ack_mode = 0;
  int rise_id[$];
  int rise_cyc[$];
  bit irq_q = 1'b0;

  timer_irq_sched_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  timer_irq_sched #(.PRESCALE(PRESCALE), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .overrun(overrun), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Channel c with reload R expires on every (R+1)-th enabled tick since its
  // last config write; the request line is a grant/show/ack/cool-down lifecycle.
  int             m_edges;
  bit [NCH-1:0]   m_pend, m_ovr, m_en, m_hit, m_cand;
  int             m_reload[NCH];
  int             m_ticks[NCH];
  bit             m_active, m_irq, m_cool, m_t, m_drop, m_acked, m_fire;
  int             m_id, m_last;

  function automatic int pick(input bit [NCH-1:0] c, input int last);
    int s;
    s = RR ? last + 1 : 0;
    for (int k = 0; k < NCH; k++)
      if (c[(s + k) % NCH]) return (s + k) % NCH;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edges = 0; m_pend = '0; m_ovr = '0; m_en = '0;
      m_active = 1'b0; m_irq = 1'b0; m_cool = 1'b0; m_id = 0; m_last = NCH - 1;
      for (int c = 0; c < NCH; c++) begin
        m_reload[c] = 0;
        m_ticks[c]  = 0;
      end
    end else begin
      m_t   = (m_edges % PRESCALE) == PRESCALE - 1;
      m_hit = '0;
      if (bus.cfg_we) m_hit[bus.cfg_ch] = 1'b1;
      m_drop  = m_active && m_hit[m_id];
      m_acked = m_active && m_irq && bus.irq_ack && !m_drop;
      m_cand  = m_pend & ~m_hit;
      for (int c = 0; c < NCH; c++) begin
        if (m_hit[c]) begin
          m_pend[c] = 1'b0; m_ovr[c] = 1'b0; m_en[c] = bus.cfg_en;
          m_reload[c] = int'(bus.cfg_reload); m_ticks[c] = 0;
        end else begin
          m_fire = m_en[c] && m_t && ((m_ticks[c] + 1) % (m_reload[c] + 1) == 0);
          if (m_en[c] && m_t) m_ticks[c]++;
          if (m_fire) begin
            if (m_pend[c] && !(m_acked && c == m_id)) m_ovr[c] = 1'b1;
            m_pend[c] = 1'b1;
          end else if (m_acked && c == m_id) begin
            m_pend[c] = 1'b0;
          end
        end
      end
      if (m_active) begin
        if (m_drop || m_acked) begin
          m_active = 1'b0; m_irq = 1'b0; m_cool = 1'b1;
        end else begin
          m_irq = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_cand != '0) begin
        m_id = pick(m_cand, m_last);
        m_last = m_id;
        m_active = 1'b1;
      end
      m_edges++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset && chk_on) begin
      check("tick", int'(tick), int'((m_edges % PRESCALE) == PRESCALE - 1));
      check("irq", int'(bus.irq), int'(m_irq));
      check("overrun", int'(overrun), int'(m_ovr));
      if (m_irq) check("irq_id", int'(bus.irq_id), m_id);
    end
  end

  // Record irq rising edges for the directed checks.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      irq_q = 1'b0;
    end else begin
      if (bus.irq && !irq_q) begin
        rise_id.push_back(int'(bus.irq_id));
        rise_cyc.push_back(cyc);
      end
      irq_q = bus.irq;
    end
  end

  // CPU acknowledge behaviour.
  always @(negedge clk) begin
    case (ack_mode)
      1:       bus.irq_ack = bus.irq;
      2:       bus.irq_ack = 1'($urandom_range(0, 1));
      3:       bus.irq_ack = bus.irq && tick;
      default: bus.irq_ack = 1'b0;
    endcase
  end

  task automatic cfg(input int ch, input bit en, input int rl);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_en = en; bus.cfg_reload = 8'(rl);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k;
    k = 0;
    while (rise_id.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int nt, ni, nbad_id, exp_id;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_en = 1'b0; bus.cfg_reload = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset irq", int'(bus.irq), 0);
    check("reset irq_id", int'(bus.irq_id), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset tick", int'(tick), 0);
    #2 reset = 1'b1;
    chk_on = 1'b1;

    // 1: unconfigured -> tick every 4 clk, no irq
    nt = 0; ni = 0;
    repeat (100) begin
      @(negedge clk);
      nt += int'(tick);
      ni += int'(bus.irq);
    end
    check("t1 tick count", nt, 25);
    check("t1 irq cycles", ni, 0);
    check("t1 overrun", int'(overrun), 0);

    // 2: ch1 reload=2, prompt ack -> one request every 12 clk
    ack_mode = 1;
    cfg(1, 1'b1, 2);
    rise_id.delete(); rise_cyc.delete();
    wait_rises(3, 100);
    check("t2 rises seen", int'(rise_id.size() >= 3), 1);
    if (rise_id.size() >= 3) begin
      check("t2 irq_id", rise_id[0], 1);
      check("t2 period a", rise_cyc[1] - rise_cyc[0], 12);
      check("t2 period b", rise_cyc[2] - rise_cyc[1], 12);
    end

    // 3: ch0 and ch2 every tick, prompt ack
    do_reset();
    ack_mode = 1;
    cfg(0, 1'b1, 0);
    cfg(2, 1'b1, 0);
    rise_id.delete(); rise_cyc.delete();
    wait_rises(4, 200);
    check("t3 rises seen", int'(rise_id.size() >= 4), 1);
    if (rise_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_id = (RR && (k % 2 == 1)) ? 2 : 0;
        check("t3 grant id", rise_id[k], exp_id);
      end
    end

    // 4: ch3 every tick, never acked -> overrun and held request; rewrite clears
    ack_mode = 0;
    cfg(0, 1'b0, 0);
    cfg(2, 1'b0, 0);
    repeat (8) @(negedge clk);
    cfg(3, 1'b1, 0);
    repeat (14) @(negedge clk);
    check("t4 overrun", int'(overrun), 8);
    check("t4 irq held", int'(bus.irq), 1);
    check("t4 irq_id", int'(bus.irq_id), 3);
    cfg(3, 1'b0, 0);
    check("t4 overrun cleared", int'(overrun), 0);
    check("t4 irq dropped", int'(bus.irq), 0);
    repeat (6) @(negedge clk);
    check("t4 stays idle", int'(bus.irq), 0);

    // 5: asynchronous reset in the middle of a request
    cfg(1, 1'b1, 0);
    rise_id.delete(); rise_cyc.delete();
    wait_rises(1, 40);
    check("t5 request raised", int'(bus.irq), 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("t5 async irq", int'(bus.irq), 0);
    check("t5 async irq_id", int'(bus.irq_id), 0);
    check("t5 async overrun", int'(overrun), 0);
    check("t5 async tick", int'(tick), 0);
    #1 reset = 1'b1;
    ni = 0;
    repeat (40) begin
      @(negedge clk);
      ni += int'(bus.irq);
    end
    check("t5 quiet after reset", ni, 0);
    check("t5 overrun after reset", int'(overrun), 0);

    // 6: ack lands on the same cycle as the next ch1 expiry
    ack_mode = 3;
    cfg(1, 1'b1, 0);
    rise_id.delete(); rise_cyc.delete();
    repeat (40) @(negedge clk);
    check("t6 overrun", int'(overrun), 0);
    check("t6 rises seen", int'(rise_id.size() >= 3), 1);
    nbad_id = 0;
    foreach (rise_id[k]) if (rise_id[k] != 1) nbad_id++;
    check("t6 ids all ch1", nbad_id, 0);

    // Randomized traffic against the model, with one async reset midway
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.cfg_we     = ($urandom_range(0, 11) == 0);
      bus.cfg_ch     = 2'($urandom_range(0, NCH - 1));
      bus.cfg_en     = ($urandom_range(0, 3) != 0);
      bus.cfg_reload = 8'($urandom_range(0, 6));
      if (i == 1500) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
